cursor_ctrl: RTL

CURSOR_CTRL -- requirements
Module: cursor_ctrl

---
 rtl/cursor_pkg.sv | 28 ++
 rtl/cursor_shape.sv | 33 +++
 rtl/cursor_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/cursor_pkg.sv
// Shared defaults, colour constants and blink state type for the grid cursor.
package cursor_pkg;

  localparam int unsigned CELL_DEF         = 32;
  localparam int unsigned GRID_COLS_DEF    = 8;
  localparam int unsigned GRID_ROWS_DEF    = 8;
  localparam int unsigned ORIGIN_X_DEF     = 0;
  localparam int unsigned ORIGIN_Y_DEF     = 0;
  localparam int unsigned BORDER_DEF       = 1;
  localparam int unsigned NOTCH_DEF        = 3;
  localparam int unsigned BLINK_FRAMES_DEF = 30;

  localparam int unsigned PIX_W       = 10;
  localparam int unsigned COLOR_W     = 12;
  localparam int unsigned BLINK_CNT_W = 8;

  localparam logic [COLOR_W-1:0] COLOR_BLACK = 12'h000;
  localparam logic [COLOR_W-1:0] COLOR_RED   = 12'hF00;
  localparam logic [COLOR_W-1:0] COLOR_GREEN = 12'h0F0;
  localparam logic [COLOR_W-1:0] COLOR_BLUE  = 12'h00F;
  localparam logic [COLOR_W-1:0] COLOR_WHITE = 12'hFFF;

  typedef enum logic {
    BLINK_VISIBLE = 1'b0,
    BLINK_HIDDEN  = 1'b1
  } blink_state_e;

endpackage

// File: rtl/cursor_shape.sv
// Outline test for one cursor cell: thin border plus solid corner squares.
module cursor_shape #(
  parameter int unsigned CELL   = 32,
  parameter int unsigned BORDER = 1,
  parameter int unsigned NOTCH  = 3
) (
  input  logic [$clog2(CELL)-1:0] lx,
  input  logic [$clog2(CELL)-1:0] ly,
  output logic                    outline
);

  localparam int unsigned LW = $clog2(CELL);

  localparam logic [LW-1:0] EDGE_LO  = LW'(BORDER);
  localparam logic [LW-1:0] EDGE_HI  = LW'(CELL - BORDER);
  localparam logic [LW-1:0] NOTCH_LO = LW'(NOTCH);
  localparam logic [LW-1:0] NOTCH_HI = LW'(CELL - NOTCH);

  logic x_edge;
  logic y_edge;
  logic x_corner;
  logic y_corner;

  // Border band on either axis, or inside both corner bands at once.
  always_comb begin
    x_edge   = (lx < EDGE_LO) || (lx >= EDGE_HI);
    y_edge   = (ly < EDGE_LO) || (ly >= EDGE_HI);
    x_corner = (lx < NOTCH_LO) || (lx >= NOTCH_HI);
    y_corner = (ly < NOTCH_LO) || (ly >= NOTCH_HI);
    outline  = x_edge || y_edge || (x_corner && y_corner);
  end

endmodule

// File: rtl/cursor_ctrl.sv
// Grid cursor: frame-synchronous movement, blink control and outline pixel generation.
module cursor_ctrl
  import cursor_pkg::*;
#(
  parameter int unsigned CELL         = CELL_DEF,
  parameter int unsigned GRID_COLS    = GRID_COLS_DEF,
  parameter int unsigned GRID_ROWS    = GRID_ROWS_DEF,
  parameter int unsigned ORIGIN_X     = ORIGIN_X_DEF,
  parameter int unsigned ORIGIN_Y     = ORIGIN_Y_DEF,
  parameter int unsigned BORDER       = BORDER_DEF,
  parameter int unsigned NOTCH        = NOTCH_DEF,
  parameter int unsigned BLINK_FRAMES = BLINK_FRAMES_DEF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [9:0]                   pixel_x,
  input  logic [9:0]                   pixel_y,
  input  logic                         frame_tick,
  input  logic                         mv_up,
  input  logic                         mv_down,
  input  logic                         mv_left,
  input  logic                         mv_right,
  input  logic                         wrap_en,
  input  logic                         blink_en,
  input  logic [11:0]                  cur_color,
  output logic                         on,
  output logic [11:0]                  color,
  output logic [$clog2(GRID_COLS)-1:0] cell_col,
  output logic [$clog2(GRID_ROWS)-1:0] cell_row,
  output logic                         moved
);

  localparam int unsigned CW = $clog2(GRID_COLS);
  localparam int unsigned RW = $clog2(GRID_ROWS);
  localparam int unsigned LW = $clog2(CELL);
  localparam int unsigned PW = PIX_W;
  localparam int unsigned BW = BLINK_CNT_W;

  localparam logic [CW-1:0] COL_MAX    = CW'(GRID_COLS - 1);
  localparam logic [RW-1:0] ROW_MAX    = RW'(GRID_ROWS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  // Pending steps: one flag plus a direction per axis.
  logic pend_h_q, pend_h_d, pend_right_q, pend_right_d;
  logic pend_v_q, pend_v_d, pend_down_q, pend_down_d;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          moved_q, moved_d;
  logic          pos_change;

  blink_state_e  state_q, state_d;
  logic [BW-1:0] cnt_q, cnt_d;

  logic              on_q, on_d;
  logic [COLOR_W-1:0] color_q, color_d;

  logic          req_h, req_v;
  logic [PW-1:0] x_left, x_right, y_top, y_bot;
  logic          in_x, in_y;
  logic [LW-1:0] lx, ly;
  logic          outline;

  // Latch requests; the frame_tick cycle commits old flags and reloads from this cycle's request.
  always_comb begin
    req_h        = mv_left ^ mv_right;
    req_v        = mv_up ^ mv_down;
    pend_h_d     = pend_h_q;
    pend_right_d = pend_right_q;
    pend_v_d     = pend_v_q;
    pend_down_d  = pend_down_q;
    if (frame_tick) begin
      pend_h_d     = req_h;
      pend_right_d = mv_right;
      pend_v_d     = req_v;
      pend_down_d  = mv_down;
    end else begin
      if (!pend_h_q && req_h) begin
        pend_h_d     = 1'b1;
        pend_right_d = mv_right;
      end
      if (!pend_v_q && req_v) begin
        pend_v_d    = 1'b1;
        pend_down_d = mv_down;
      end
    end
  end

  // Commit pending steps on frame_tick with wrap or saturate at the grid edges.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (frame_tick && pend_h_q) begin
      if (pend_right_q) begin
        if (col_q == COL_MAX) col_d = wrap_en ? '0 : col_q;
        else                  col_d = col_q + CW'(1);
      end else begin
        if (col_q == '0)      col_d = wrap_en ? COL_MAX : col_q;
        else                  col_d = col_q - CW'(1);
      end
    end
    if (frame_tick && pend_v_q) begin
      if (pend_down_q) begin
        if (row_q == ROW_MAX) row_d = wrap_en ? '0 : row_q;
        else                  row_d = row_q + RW'(1);
      end else begin
        if (row_q == '0)      row_d = wrap_en ? ROW_MAX : row_q;
        else                  row_d = row_q - RW'(1);
      end
    end
    pos_change = (col_d != col_q) || (row_d != row_q);
    moved_d    = pos_change;
  end

  // Blink next-state: disabled or moved forces VISIBLE, otherwise count frames and toggle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!blink_en || pos_change) begin
      state_d = BLINK_VISIBLE;
      cnt_d   = '0;
    end else if (frame_tick) begin
      if (cnt_q == BLINK_LAST) begin
        cnt_d   = '0;
        state_d = (state_q == BLINK_VISIBLE) ? BLINK_HIDDEN : BLINK_VISIBLE;
      end else begin
        cnt_d = cnt_q + BW'(1);
      end
    end
  end

  // Footprint window of the committed cell and local coordinates inside it.
  always_comb begin
    x_left  = PW'(ORIGIN_X) + (PW'(col_q) << LW);
    y_top   = PW'(ORIGIN_Y) + (PW'(row_q) << LW);
    x_right = x_left + PW'(CELL - 1);
    y_bot   = y_top + PW'(CELL - 1);
    in_x    = (pixel_x >= x_left) && (pixel_x <= x_right);
    in_y    = (pixel_y >= y_top) && (pixel_y <= y_bot);
    lx      = LW'(pixel_x - x_left);
    ly      = LW'(pixel_y - y_top);
  end

  cursor_shape #(
    .CELL   (CELL),
    .BORDER (BORDER),
    .NOTCH  (NOTCH)
  ) u_shape (
    .lx      (lx),
    .ly      (ly),
    .outline (outline)
  );

  // Pixel output next-state.
  always_comb begin
    on_d    = in_x && in_y && outline && (state_q == BLINK_VISIBLE);
    color_d = on_d ? cur_color : COLOR_BLACK;
  end

  // Position, pending flags and move pulse registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_h_q     <= 1'b0;
      pend_right_q <= 1'b0;
      pend_v_q     <= 1'b0;
      pend_down_q  <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      moved_q      <= 1'b0;
    end else begin
      pend_h_q     <= pend_h_d;
      pend_right_q <= pend_right_d;
      pend_v_q     <= pend_v_d;
      pend_down_q  <= pend_down_d;
      col_q        <= col_d;
      row_q        <= row_d;
      moved_q      <= moved_d;
    end
  end

  // Blink state register and frame counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= BLINK_VISIBLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered pixel outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      on_q    <= 1'b0;
      color_q <= COLOR_BLACK;
    end else begin
      on_q    <= on_d;
      color_q <= color_d;
    end
  end

  assign on       = on_q;
  assign color    = color_q;
  assign cell_col = col_q;
  assign cell_row = row_q;
  assign moved    = moved_q;

endmodule
